sal_rw_bus_arb: RTL

- Arbitrates CAS-level access to the shared DQ bus between the read path and the write path of the SAL controller.
- Produces the single-cycle `rd_gnt` / `wr_gnt` pulses consumed by the read and write datapaths.
- Write grant drives the write-enable shift register; read grant drives the read-capture logic.
- Enforces CAS-to-CAS spacing and read/write bus turnaround, and batches writes with a watermark-based drain policy plus a write-starvation guard.

---
 rtl/sal_rw_bus_arb_if.sv | 27 ++
 rtl/sal_rw_bus_arb.sv | 95 +++++++++
 2 files changed

// File: rtl/sal_rw_bus_arb_if.sv
// DQ-bus arbitration interface for the SAL controller: CAS requests and timing in,
// grants and mode status out. The requester drives the master side.
interface sal_rw_bus_arb_if #(
  parameter int unsigned PEND_W = 5,
  parameter int unsigned TW     = 4
);
  logic              rd_req;
  logic              wr_req;
  logic [PEND_W-1:0] wr_pend_cnt;
  logic [TW-1:0]     t_ccd;
  logic [TW-1:0]     t_wtr;
  logic [TW-1:0]     t_rtw;
  logic              rd_gnt;
  logic              wr_gnt;
  logic              wr_mode;
  logic [15:0]       switch_cnt;

  modport master (
    output rd_req, wr_req, wr_pend_cnt, t_ccd, t_wtr, t_rtw,
    input  rd_gnt, wr_gnt, wr_mode, switch_cnt
  );

  modport slave (
    input  rd_req, wr_req, wr_pend_cnt, t_ccd, t_wtr, t_rtw,
    output rd_gnt, wr_gnt, wr_mode, switch_cnt
  );
endinterface

// File: rtl/sal_rw_bus_arb.sv
// Read/write CAS arbiter for the shared DQ bus: spacing/turnaround timers, watermark-based
// write drain with a starvation guard, and single-cycle grant pulses.
module sal_rw_bus_arb #(
  parameter int unsigned PEND_W   = 5,
  parameter int unsigned HI_WM    = 6,
  parameter int unsigned LO_WM    = 2,
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned TW       = 4
) (
  input  logic             clk,
  input  logic             rst,
  sal_rw_bus_arb_if.slave  bus
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic ST_RD = 1'b0;
  localparam logic ST_WR = 1'b1;

  if (HI_WM <= LO_WM || MAX_WAIT < 1) begin : g_bad_param
    $error("sal_rw_bus_arb: HI_WM must exceed LO_WM and MAX_WAIT must be at least 1");
  end

  logic              r_mode;
  logic [TW-1:0]     r_ccd_cnt;
  logic [TW-1:0]     r_wtr_cnt;
  logic [TW-1:0]     r_rtw_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_wr_served;
  logic [15:0]       r_switch_cnt;

  logic w_rd_gnt;
  logic w_wr_gnt;
  logic w_mode_d;
  logic w_mode_chg;
  logic w_hi;
  logic w_lo;
  logic w_wait_exp;

  // A programmed spacing of 0 behaves like 1: the counter reloads to 0.
  function automatic logic [TW-1:0] f_load(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  function automatic logic [TW-1:0] f_dec(input logic [TW-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  assign w_rd_gnt   = bus.rd_req & (r_mode == ST_RD) & (r_ccd_cnt == '0) & (r_wtr_cnt == '0);
  assign w_wr_gnt   = bus.wr_req & (r_mode == ST_WR) & (r_ccd_cnt == '0) & (r_rtw_cnt == '0);
  assign w_hi       = bus.wr_pend_cnt >= PEND_W'(HI_WM);
  assign w_lo       = bus.wr_pend_cnt <= PEND_W'(LO_WM);
  assign w_wait_exp = r_wait_cnt >= WAIT_W'(MAX_WAIT - 1);
  assign w_mode_chg = w_mode_d != r_mode;

  always_comb begin
    w_mode_d = r_mode;
    case (r_mode)
      ST_RD: if (bus.wr_req & (w_hi | ~bus.rd_req | w_wait_exp)) w_mode_d = ST_WR;
      ST_WR: if (~bus.wr_req | (bus.rd_req & r_wr_served & w_lo)) w_mode_d = ST_RD;
      default: w_mode_d = ST_RD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode       <= ST_RD;
      r_ccd_cnt    <= '0;
      r_wtr_cnt    <= '0;
      r_rtw_cnt    <= '0;
      r_wait_cnt   <= '0;
      r_wr_served  <= 1'b0;
      r_switch_cnt <= '0;
    end else begin
      r_mode <= w_mode_d;
      if (w_mode_chg) r_switch_cnt <= r_switch_cnt + 16'd1;

      r_ccd_cnt <= (w_rd_gnt | w_wr_gnt) ? f_load(bus.t_ccd) : f_dec(r_ccd_cnt);
      r_wtr_cnt <= w_wr_gnt ? f_load(bus.t_wtr) : f_dec(r_wtr_cnt);
      r_rtw_cnt <= w_rd_gnt ? f_load(bus.t_rtw) : f_dec(r_rtw_cnt);

      // Cleared on drain entry so every drain episode issues at least one write.
      if (w_mode_chg && w_mode_d == ST_WR) r_wr_served <= 1'b0;
      else if (w_wr_gnt)                   r_wr_served <= 1'b1;

      if (w_mode_chg || !bus.wr_req || r_mode == ST_WR) r_wait_cnt <= '0;
      else if (r_wait_cnt != WAIT_W'(MAX_WAIT))       r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign bus.rd_gnt     = w_rd_gnt;
  assign bus.wr_gnt     = w_wr_gnt;
  assign bus.wr_mode    = r_mode;
  assign bus.switch_cnt = r_switch_cnt;

endmodule
